// File: rtl/md_ctrl.sv
// HI/LO multiply/divide sequencer for the E stage: fixed-latency busy countdown,
// pending result capture, and the combinational D-stage stall.
module md_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_D,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

  state_t      state, state_next;
  logic [3:0]  count, count_next;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_wr;
  logic        issue_long, issue_move, finish;

  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, sdiv_den, udiv_den;
  logic [31:0] sq, sr, res_hi, res_lo;

  // Result datapath; zero divisors are steered to 1 so the dividers never see 0
  // (the result is discarded anyway through pend_wr).
  always_comb begin
    prod_s   = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    prod_u   = {32'b0, src_a} * {32'b0, src_b};
    abs_a    = src_a[31] ? -src_a : src_a;
    abs_b    = src_b[31] ? -src_b : src_b;
    sdiv_den = (src_b == 32'd0) ? 32'd1 : abs_b;
    udiv_den = (src_b == 32'd0) ? 32'd1 : src_b;
    sq       = abs_a / sdiv_den;
    sr       = abs_a % sdiv_den;
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    case (md_op[1:0])
      2'd0: {res_hi, res_lo} = prod_s;
      2'd1: {res_hi, res_lo} = prod_u;
      2'd2: begin
        res_lo = (src_a[31] ^ src_b[31]) ? -sq : sq;
        res_hi = src_a[31] ? -sr : sr;
      end
      default: begin
        res_lo = src_a / udiv_den;
        res_hi = src_a % udiv_den;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (start && !md_op[2]) begin
          state_next = BUSY;
          count_next = md_op[1] ? DIV_LOAD : MUL_LOAD;
        end
      end
      BUSY: begin
        if (count == 4'd0) state_next = IDLE;
        else               count_next = count - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == BUSY);
    finish     = busy && (count == 4'd0);
    issue_long = (state == IDLE) && start && !md_op[2];
    issue_move = (state == IDLE) && start && (md_op[2:1] == 2'b10);
    stall_D    = md_use_D && (busy || (start && (md_op <= 3'd3)));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= finish;
      if (issue_long) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_wr <= !(md_op[1] && (src_b == 32'd0));
      end
      if (finish && pend_wr) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end else if (issue_move) begin
        if (md_op[0]) lo <= src_a;
        else          hi <= src_a;
      end
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: latency, HI/LO results, divide corner cases,
// stall generation, ignored issues while busy and mid-operation reset.
module tb_md_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, md_use_D;
  logic [2:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        busy, stall_D, done;
  logic [31:0] hi, lo;
  int          pass_count = 0;
  int          total_count = 0;

  md_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .md_use_D(md_use_D),
    .busy(busy), .stall_D(stall_D), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_count++;
    if (got !== exp)
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    else
      pass_count++;
  endtask

  // Drives one issue cycle, leaving the bench in the first cycle after the issue edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
    tick();
    start = 1'b0;
    md_op = 3'd7;
  endtask

  task automatic runLong(input int n, input logic [31:0] old_hi, input logic [31:0] old_lo,
                         input string tag);
    for (int i = 1; i <= n; i++) begin
      checkOutput({tag, " busy"}, 32'(busy), 32'd1);
      checkOutput({tag, " done early"}, 32'(done), 32'd0);
      if (i == n) begin
        checkOutput({tag, " hi held"}, hi, old_hi);
        checkOutput({tag, " lo held"}, lo, old_lo);
      end
      tick();
    end
    checkOutput({tag, " busy end"}, 32'(busy), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd1);
  endtask

  task automatic endOp(input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
    checkOutput({tag, " hi"}, hi, exp_hi);
    checkOutput({tag, " lo"}, lo, exp_lo);
    tick();
    checkOutput({tag, " done drop"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b0; start = 1'b0; md_use_D = 1'b0;
    md_op = 3'd7; src_a = 32'd0; src_b = 32'd0;
    tick(); tick();
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    checkOutput("reset stall", 32'(stall_D), 32'd0);
    reset = 1'b1;
    tick();

    applyStimulus(3'd0, 32'hFFFFFFFE, 32'd3);
    runLong(5, 32'd0, 32'd0, "mult");
    endOp(32'hFFFFFFFF, 32'hFFFFFFFA, "mult");

    applyStimulus(3'd3, 32'd100, 32'd7);
    runLong(10, 32'hFFFFFFFF, 32'hFFFFFFFA, "divu");
    endOp(32'd2, 32'd14, "divu");

    applyStimulus(3'd2, 32'hFFFFFFF9, 32'd2);
    runLong(10, 32'd2, 32'd14, "div neg");
    endOp(32'hFFFFFFFF, 32'hFFFFFFFD, "div neg");

    applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    runLong(5, 32'hFFFFFFFF, 32'hFFFFFFFD, "multu");
    endOp(32'hFFFFFFFE, 32'h00000001, "multu");

    applyStimulus(3'd2, 32'h80000000, 32'hFFFFFFFF);
    runLong(10, 32'hFFFFFFFE, 32'h00000001, "div ovf");
    endOp(32'd0, 32'h80000000, "div ovf");

    // Divide by zero must leave HI/LO untouched.
    applyStimulus(3'd4, 32'h11, 32'd0);
    checkOutput("mthi hi", hi, 32'h11);
    applyStimulus(3'd5, 32'h22, 32'd0);
    checkOutput("mtlo lo", lo, 32'h22);
    checkOutput("mtlo busy", 32'(busy), 32'd0);
    applyStimulus(3'd2, 32'd1234, 32'd0);
    runLong(10, 32'h11, 32'h22, "div0");
    endOp(32'h11, 32'h22, "div0");

    md_use_D = 1'b1;
    start = 1'b1; md_op = 3'd0; src_a = 32'd3; src_b = 32'd5;
    #1;
    checkOutput("stall issue", 32'(stall_D), 32'd1);
    tick();
    start = 1'b0; md_op = 3'd7;
    for (int i = 1; i <= 5; i++) begin
      checkOutput("stall busy", 32'(stall_D), 32'd1);
      tick();
    end
    checkOutput("stall release", 32'(stall_D), 32'd0);
    endOp(32'd0, 32'd15, "stall mult");
    start = 1'b1; md_op = 3'd7;
    #1;
    checkOutput("stall nop", 32'(stall_D), 32'd0);
    tick();
    start = 1'b0;
    checkOutput("nop busy", 32'(busy), 32'd0);
    checkOutput("nop lo", lo, 32'd15);

    md_use_D = 1'b0;
    start = 1'b1; md_op = 3'd0; src_a = 32'd4; src_b = 32'd4;
    #1;
    checkOutput("nouse stall issue", 32'(stall_D), 32'd0);
    tick();
    start = 1'b0; md_op = 3'd7;
    for (int i = 1; i <= 5; i++) begin
      checkOutput("nouse stall busy", 32'(stall_D), 32'd0);
      tick();
    end
    endOp(32'd0, 32'd16, "nouse mult");

    applyStimulus(3'd4, 32'hDEADBEEF, 32'd0);
    checkOutput("mthi2 hi", hi, 32'hDEADBEEF);
    checkOutput("mthi2 busy", 32'(busy), 32'd0);
    checkOutput("mthi2 done", 32'(done), 32'd0);

    // Issues arriving while busy must be dropped.
    applyStimulus(3'd3, 32'd100, 32'd7);
    for (int i = 1; i <= 10; i++) begin
      checkOutput("ign busy", 32'(busy), 32'd1);
      if (i == 3) begin
        start = 1'b1; md_op = 3'd0; src_a = 32'd1; src_b = 32'd1;
      end else if (i == 5) begin
        start = 1'b1; md_op = 3'd5; src_a = 32'h55; src_b = 32'd0;
      end
      tick();
      start = 1'b0; md_op = 3'd7;
    end
    checkOutput("ign done", 32'(done), 32'd1);
    endOp(32'd2, 32'd14, "ign");
    checkOutput("ign idle", 32'(busy), 32'd0);

    applyStimulus(3'd1, 32'd7, 32'd6);
    tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("mreset busy", 32'(busy), 32'd0);
    checkOutput("mreset hi", hi, 32'd0);
    checkOutput("mreset lo", lo, 32'd0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("mreset no done", 32'(done), 32'd0);
      tick();
    end
    applyStimulus(3'd0, 32'd2, 32'd3);
    runLong(5, 32'd0, 32'd0, "post reset");
    endOp(32'd0, 32'd6, "post reset");

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
Sequencing controller for the multiply/divide resource (HI/LO) used by the E stage of the 5-stage pipeline.
- Accepts mult/div/mthi/mtlo issues from E.
- Models fixed multi-cycle latency with a countdown and holds HI/LO.
- Raises the D-stage stall while a D-stage instruction touching HI/LO would collide with an in-flight operation.

Parameters:
MUL_CYCLES, 5, busy duration of MULT/MULTU in cycles (legal range 1..15)
DIV_CYCLES, 10, busy duration of DIV/DIVU in cycles (legal range 1..15)

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
start  input  1  E stage issues an md_op this cycle
md_op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, 6/7=no-op
src_a  input  32  rs value (forwarded) from E
src_b  input  32  rt value (forwarded) from E
md_use_D  input  1  instruction in D is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
busy  output  1  long operation in flight
stall_D  output  1  freeze PC/F_D, bubble D_E
done  output  1  one-cycle pulse in the cycle new HI/LO first become visible
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (reset==0 at posedge), including mid-operation:
  - state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0.
  - Any pending result is discarded.
- States: IDLE, BUSY. Counter is 4 bits.
- IDLE, start=1, md_op in 0..3:
  - At that edge, capture the result (computed from src_a/src_b) into pending regs.
  - Go to BUSY with counter=N-1, where N=MUL_CYCLES or DIV_CYCLES.
- BUSY, at each edge:
  - If counter!=0: counter-1.
  - If counter==0: hi/lo<=pending, done<=1, go to IDLE.
  - Net effect: busy=1 for exactly N cycles, and hi/lo update at the edge ending the last busy cycle.
- done deasserts on the following edge unless re-triggered.
- IDLE, start=1, md_op=4/5: hi<=src_a (MTHI) or lo<=src_a (MTLO) at that edge. busy stays 0, done stays 0.
- md_op 6/7: no state change.
- start=1 while BUSY: ignored; no capture, counter unaffected. stall_D makes this unreachable in a correct pipeline, and the bench checks it is harmless.
- MULT: signed 64-bit product {hi,lo}.
- MULTU: unsigned 64-bit product {hi,lo}.
- DIV: signed; lo=quotient truncated toward zero, hi=remainder with the dividend's sign.
- DIVU: unsigned; lo=quotient, hi=remainder.
- Divide by zero (src_b==0): busy for DIV_CYCLES as normal, but at completion hi/lo are left unchanged. done still pulses.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no trap.
- stall_D = md_use_D & (busy | (start & md_op<=3)). This is combinational, with no registered delay.
- hi/lo are read-only outputs; mfhi/mflo read them directly in E when not stalled.

Test Plan:
- MULT src_a=0xFFFFFFFE (-2), src_b=3, start at cycle 0 -> busy=1 cycles 1..5; hi=0xFFFFFFFF, lo=0xFFFFFFFA visible and done=1 in cycle 6 only.
- DIVU 100/7 at cycle 0 -> busy cycles 1..10; cycle 11: lo=14, hi=2, done=1. Then DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV src_b=0 after prior hi=0x11, lo=0x22 -> busy 10 cycles, done pulses, hi/lo remain 0x11/0x22.
- MULT issued with md_use_D=1 held -> stall_D=1 in the issue cycle and cycles 1..5, 0 in cycle 6. md_use_D=0 -> stall_D never asserts.
- MTHI src_a=0xDEADBEEF -> hi=0xDEADBEEF next cycle, busy=0. Extra start pulses during a DIV -> counter and result unaffected.
- reset=0 for one edge at cycle 3 of a MULTU -> next cycle busy=0, hi=lo=0, done never pulses. A new MULT issued afterwards completes normally.
